// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with a direct-mapped branch
// target buffer (valid / tag / target / 2-bit saturating counter per entry).
// The fetch side looks up the current pc and may jump to a predicted target.
// The execute side resolves branches, trains the table and redirects the pc
// when a prediction turns out wrong.
module pc_gen #(
   parameter int          BTB_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter int          IDX_W       = $clog2(BTB_ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic [31:0] pc,
   output logic        branch,
   output logic        pred_taken,
   output logic [31:0] pred_target
);

   localparam int TAG_W = 32 - IDX_W;

   // Predictor table storage
   logic             valid_q [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
   logic [31:0]      tgt_q   [BTB_ENTRIES];
   logic [1:0]       ctr_q   [BTB_ENTRIES];

   // Fetch-side state
   logic [31:0] pc_q, pc_d;
   logic        pred_taken_q, pred_taken_d;
   logic [31:0] pred_target_q, pred_target_d;

   // Fetch lookup results
   logic [IDX_W-1:0] f_idx_s;
   logic             f_hit_s;
   logic             f_take_s;
   logic [31:0]      f_tgt_s;

   // Resolve-side signals
   logic             mispredict_s;
   logic [IDX_W-1:0] e_idx_s;
   logic             e_hit_s;
   logic             upd_en_s;
   logic [1:0]       upd_ctr_d;
   logic [31:0]      upd_tgt_d;

   assign pc          = pc_q;
   assign pred_taken  = pred_taken_q;
   assign pred_target = pred_target_q;
   assign branch      = mispredict_s & ~rst;

   // Look up the current pc; the table read always sees pre-update contents
   always_comb begin
      f_idx_s  = pc_q[IDX_W-1:0];
      f_hit_s  = valid_q[f_idx_s] && (tag_q[f_idx_s] == pc_q[31:IDX_W]);
      f_take_s = f_hit_s && ctr_q[f_idx_s][1];
      if (f_take_s) begin
         f_tgt_s = tgt_q[f_idx_s];
      end else begin
         f_tgt_s = 32'd0;
      end
   end

   // Detect a wrong direction or a wrong target on the resolving branch
   always_comb begin
      mispredict_s = 1'b0;
      if (ex_valid) begin
         if (ex_taken != ex_pred_taken) begin
            mispredict_s = 1'b1;
         end else if (ex_taken && (ex_target != ex_pred_target)) begin
            mispredict_s = 1'b1;
         end else begin
            mispredict_s = 1'b0;
         end
      end else begin
         mispredict_s = 1'b0;
      end
   end

   // Next pc: redirect beats stall beats prediction beats sequential fetch
   always_comb begin
      pc_d = pc_q + 32'd1;
      if (mispredict_s) begin
         if (ex_taken) begin
            pc_d = ex_target;
         end else begin
            pc_d = ex_pc + 32'd1;
         end
      end else if (stall) begin
         pc_d = pc_q;
      end else if (f_take_s) begin
         pc_d = f_tgt_s;
      end else begin
         pc_d = pc_q + 32'd1;
      end
   end

   // Prediction reported for the instruction leaving imem; squashed on redirect
   always_comb begin
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      if (mispredict_s) begin
         pred_taken_d  = 1'b0;
         pred_target_d = 32'd0;
      end else if (stall) begin
         pred_taken_d  = pred_taken_q;
         pred_target_d = pred_target_q;
      end else begin
         pred_taken_d  = f_take_s;
         pred_target_d = f_tgt_s;
      end
   end

   // Training values for the entry addressed by the resolving branch
   always_comb begin
      e_idx_s   = ex_pc[IDX_W-1:0];
      e_hit_s   = valid_q[e_idx_s] && (tag_q[e_idx_s] == ex_pc[31:IDX_W]);
      upd_en_s  = ex_valid && (ex_taken || e_hit_s);
      upd_ctr_d = ctr_q[e_idx_s];
      upd_tgt_d = tgt_q[e_idx_s];
      if (ex_taken) begin
         upd_tgt_d = ex_target;
         if (e_hit_s) begin
            if (ctr_q[e_idx_s] == 2'd3) begin
               upd_ctr_d = 2'd3;
            end else begin
               upd_ctr_d = ctr_q[e_idx_s] + 2'd1;
            end
         end else begin
            upd_ctr_d = 2'd2;
         end
      end else begin
         if (ctr_q[e_idx_s] == 2'd0) begin
            upd_ctr_d = 2'd0;
         end else begin
            upd_ctr_d = ctr_q[e_idx_s] - 2'd1;
         end
      end
   end

   // Fetch-side registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         pred_taken_q  <= 1'b0;
         pred_target_q <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
      end
   end

   // Predictor table write; trains on every resolve regardless of stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= 32'd0;
            ctr_q[i]   <= 2'd1;
         end
      end else if (upd_en_s) begin
         valid_q[e_idx_s] <= 1'b1;
         tag_q[e_idx_s]   <= ex_pc[31:IDX_W];
         tgt_q[e_idx_s]   <= upd_tgt_d;
         ctr_q[e_idx_s]   <= upd_ctr_d;
      end else begin
         valid_q[e_idx_s] <= valid_q[e_idx_s];
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a driver applies directed then random
// stimulus at the falling edge, runs a behavioural predictor model and queues
// the expected post-edge outputs; a monitor pops and compares after each
// rising edge.
module tb_pc_gen;

   localparam int NE = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic [31:0] pc;
   logic        branch;
   logic        pred_taken;
   logic [31:0] pred_target;

   pc_gen #(.BTB_ENTRIES(NE), .RESET_PC(32'd0)) dut (
      .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .pc(pc), .branch(branch), .pred_taken(pred_taken),
      .pred_target(pred_target)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        br;
      logic [31:0] pc;
      logic        pt;
      logic [31:0] ptgt;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: each slot remembers the full pc that owns it
   bit          m_v   [NE];
   logic [31:0] m_own [NE];
   logic [31:0] m_tgt [NE];
   int          m_ctr [NE];
   logic [31:0] m_pc;
   logic        m_pt;
   logic [31:0] m_ptgt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NE; i++) begin
         m_v[i] = 1'b0; m_own[i] = 32'd0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
      end
      m_pc = 32'd0; m_pt = 1'b0; m_ptgt = 32'd0;
   endtask

   // One cycle: apply inputs, advance the model, queue the expectation
   task automatic drive(input bit r, input bit st, input bit exv,
                        input logic [31:0] expc, input bit ext,
                        input logic [31:0] extgt, input bit expt,
                        input logic [31:0] exptgt);
      exp_t e;
      bit   mis, fh, ftake, eh;
      int   fi, ei;
      logic [31:0] npc;
      @(negedge clk);
      rst = r; stall = st; ex_valid = exv; ex_pc = expc; ex_taken = ext;
      ex_target = extgt; ex_pred_taken = expt; ex_pred_target = exptgt;
      if (r) begin
         model_reset();
         e = '{br: 1'b0, pc: 32'd0, pt: 1'b0, ptgt: 32'd0};
      end else begin
         mis = exv && ((ext != expt) || (ext && expt && extgt != exptgt));
         fi = int'(m_pc % NE);
         fh = m_v[fi] && (m_own[fi] == m_pc);
         ftake = fh && (m_ctr[fi] >= 2);
         if (mis) npc = ext ? extgt : expc + 32'd1;
         else if (st) npc = m_pc;
         else if (ftake) npc = m_tgt[fi];
         else npc = m_pc + 32'd1;
         if (mis) begin
            m_pt = 1'b0; m_ptgt = 32'd0;
         end else if (!st) begin
            m_pt = ftake; m_ptgt = ftake ? m_tgt[fi] : 32'd0;
         end
         if (exv) begin
            ei = int'(expc % NE);
            eh = m_v[ei] && (m_own[ei] == expc);
            if (ext && eh) begin
               m_ctr[ei] = (m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1;
               m_tgt[ei] = extgt;
            end else if (ext) begin
               m_v[ei] = 1'b1; m_own[ei] = expc; m_tgt[ei] = extgt; m_ctr[ei] = 2;
            end else if (eh) begin
               m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
            end
         end
         m_pc = npc;
         e = '{br: mis, pc: m_pc, pt: m_pt, ptgt: m_ptgt};
      end
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
   endtask

   // Resolve a taken branch as mispredicted to force the pc to a target
   task automatic jump(input logic [31:0] from_pc, input logic [31:0] to_pc);
      drive(0, 0, 1, from_pc, 1, to_pc, 0, 32'd0);
   endtask

   // Monitor: compare DUT outputs just after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("branch", {31'd0, branch}, {31'd0, e.br});
            check("pc", pc, e.pc);
            check("pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
            check("pred_target", pred_target, e.ptgt);
         end
      end
   end

   initial begin
      int wait_cnt;
      logic [31:0] a, b, c;
      rst = 1'b1; stall = 1'b0; ex_valid = 1'b1; ex_pc = 32'd3; ex_taken = 1'b1;
      ex_target = 32'd7; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
      model_reset();
      #1;
      check("reset_pc", pc, 32'd0);
      check("reset_branch_forced_low", {31'd0, branch}, 32'd0);
      check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
      // reset pulse then free-running fetch 1,2
      drive(1, 0, 1, 32'd3, 1, 32'd7, 0, 32'd0);
      idle(2);
      // stall at pc=2 for three cycles, then resume
      drive(0, 1, 0, 32'd0, 0, 32'd0, 0, 32'd0);
      drive(0, 1, 0, 32'd0, 0, 32'd0, 0, 32'd0);
      drive(0, 1, 0, 32'd0, 0, 32'd0, 0, 32'd0);
      idle(2);
      // train pc=2 -> 9, then refetch pc=2 to see the prediction
      drive(0, 0, 1, 32'd2, 1, 32'd9, 0, 32'd0);
      idle(1);
      jump(32'd20, 32'd2);
      idle(3);
      // two not-taken resolves drop the counter to 0
      drive(0, 0, 1, 32'd2, 0, 32'd0, 0, 32'd0);
      drive(0, 0, 1, 32'd2, 0, 32'd0, 0, 32'd0);
      jump(32'd20, 32'd2);
      idle(2);
      // mispredict with stall in the same cycle
      drive(0, 1, 1, 32'd5, 0, 32'd0, 1, 32'd8);
      idle(2);
      // allocate entry 2 for pc=2, then fetch aliasing pc=18
      drive(0, 0, 1, 32'd2, 1, 32'd9, 0, 32'd0);
      jump(32'd21, 32'd18);
      idle(2);
      // pc wrap at the top of the address space
      jump(32'd22, 32'hFFFF_FFFE);
      idle(3);
      // reset in the middle of a redirect
      jump(32'd23, 32'd30);
      drive(1, 0, 1, 32'd4, 1, 32'd11, 0, 32'd0);
      idle(2);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         a = 32'($urandom_range(0, 40));
         b = 32'($urandom_range(0, 40));
         c = ($urandom_range(0, 1) == 0) ? b : 32'($urandom_range(0, 40));
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, a, 1'($urandom_range(0, 1)), b,
               1'($urandom_range(0, 1)), c);
      end
      idle(1);
      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         #2;
         wait_cnt++;
      end
      if (q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, number of direct-mapped predictor entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'd0, word address fetched first after reset.
REQ-003 SHALL have parameter IDX_W, default $clog2(BTB_ENTRIES), index width.
REQ-004 SHALL have port clk  in  1  single clock; all state on posedge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port stall  in  1  hold current pc (downstream not ready).
REQ-007 SHALL have port ex_valid  in  1  a branch is resolved this cycle.
REQ-008 SHALL have port ex_pc  in  32  word address of the resolved branch.
REQ-009 SHALL have port ex_taken  in  1  actual direction of the resolved branch.
REQ-010 SHALL have port ex_target  in  32  actual taken target (word address).
REQ-011 SHALL have port ex_pred_taken  in  1  direction predicted for that branch at fetch.
REQ-012 SHALL have port ex_pred_target  in  32  target predicted for that branch at fetch.
REQ-013 SHALL have port pc  out  32  word address presented to instruction memory.
REQ-014 SHALL have port branch  out  1  flush pulse to instruction memory (redirect).
REQ-015 SHALL have port pred_taken  out  1  prediction for instruction now leaving imem (pc of previous fetch).
REQ-016 SHALL have port pred_target  out  32  predicted target matching pred_taken.

Function
REQ-017 SHALL hold per entry: valid(1), tag(32-IDX_W), target(32), ctr(2-bit saturating); index = pc[IDX_W-1:0], tag = pc[31:IDX_W].
REQ-018 SHALL compute lookup hit = valid & tag match for current pc; predict taken iff hit and ctr >= 2.
REQ-019 SHALL compute mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
REQ-020 SHALL drive branch combinationally = mispredict & !rst, same cycle as detection.
REQ-021 SHALL select next pc, priority high to low: mispredict -> (ex_taken ? ex_target : ex_pc+1); stall -> pc; predicted taken -> entry target; else pc+1.
REQ-022 SHALL wrap pc+1 modulo 2^32 (32'hFFFFFFFF -> 0).
REQ-023 SHALL register pred_taken/pred_target from the lookup each cycle pc advances; on stall hold them; on mispredict clear both to 0 next cycle.
REQ-024 SHALL update the table on every ex_valid, independent of stall.
REQ-025 SHALL on ex_taken with hit on ex_pc: ctr increments saturating at 3, target <= ex_target.
REQ-026 SHALL on ex_taken with miss: allocate (overwrite) entry: valid=1, tag, target=ex_target, ctr=2.
REQ-027 SHALL on !ex_taken with hit: ctr decrements saturating at 0; entry stays valid.
REQ-028 SHALL on !ex_taken with miss: no table change.
REQ-029 SHALL make lookup read pre-update contents when the fetch index equals the update index in the same cycle; update visible next cycle.
REQ-030 SHALL give pc a 1-cycle redirect latency: mispredict at edge N puts corrected pc on pc after edge N.

Reset
REQ-031 SHALL on rst asynchronously set pc=RESET_PC, pred_taken=0, pred_target=0, all valid=0, all ctr=1.
REQ-032 SHALL force branch=0 while rst is high, regardless of ex_valid.
REQ-033 SHALL ignore stall and ex_* while rst is high; first increment on first posedge after rst deasserts.
REQ-034 SHALL on rst mid-redirect discard the pending redirect; pc returns to RESET_PC.

Verification
REQ-035 SHALL cover: rst pulse, no ex_valid, stall=0 -> pc 0,1,2,3 on successive cycles, branch=0, pred_taken=0.
REQ-036 SHALL cover: stall=1 for 3 cycles at pc=2 -> pc stays 2, then resumes 3.
REQ-037 SHALL cover: ex_valid, ex_pc=2, ex_taken=1, ex_target=9, ex_pred_taken=0 -> branch=1 that cycle, next pc=9; later fetch of pc=2 -> next pc=9, pred_taken=1, pred_target=9 one cycle later.
REQ-038 SHALL cover: after REQ-037, two resolves pc=2 not taken -> ctr 2->1->0; next fetch of pc=2 -> next pc=3, no prediction.
REQ-039 SHALL cover: mispredict (ex_taken=0, ex_pred_taken=1, ex_pc=5) with stall=1 same cycle -> branch=1, next pc=6, pred_taken=0.
REQ-040 SHALL cover: entry 2 allocated for pc=2, fetch pc=18 (BTB_ENTRIES=16) -> tag miss, next pc=19, no prediction.
